reorder_buffer_mw: RTL and testbench
====================================

// Module: reorder_buffer_mw
// PURPOSE
//  Parametrised in-order-retire ROB for the OOO core: DEPTH entries, WB_CH writeback ports, up to COMMIT_W retires/cycle.
//  Sits between DC (dispatch/rename), EXE/LSU (writeback, mispredict) and the rename map (commit, rollback).
//  Adds multi-commit and cycle-by-cycle walk-back recovery that restores RAT and frees physical regs of squashed entries.
// PARAMETERS
//  DEPTH     8  entries; power of 2, >=4; IW=$clog2(DEPTH)
//  WB_CH     2  independent writeback channels (ALU/MUL, LSU, ...)
//  COMMIT_W  2  max retires per cycle (1..4, <=DEPTH)
// PORTS
//  clk             in   1         clock; single clock domain
//  rst             in   1         synchronous, active-high reset
//  disp_valid      in   1         DC offers one instruction
//  disp_ready      out  1         ROB accepts (not full, state IDLE, no mispredict this cycle)
//  disp_A_rd       in   6         architectural rd
//  disp_P_rd_new   in   7         newly allocated physical rd
//  disp_P_rd_old   in   7         previous mapping of A_rd
//  disp_wb_en      in   1         instruction writes rd
//  disp_is_ld      in   1         load (LQ commit accounting)
//  disp_is_st      in   1         store (SQ commit accounting)
//  disp_rob_idx    out  IW        index allocated on handshake (= tail)
//  wb_valid        in   WB_CH     per-channel completion
//  wb_rob_idx      in   WB_CH*IW  per-channel entry index
//  wb_data         in   WB_CH*32  per-channel result (stored only with ROB_DATA_EN)
//  mispredict      in   1         branch at mis_rob_idx resolved wrong
//  mis_rob_idx     in   IW        mispredicting entry (kept; younger squashed)
//  commit_valid    out  COMMIT_W  lane i retires entry head+i
//  commit_A_rd     out  COMMIT_W*6
//  commit_P_rd_new out  COMMIT_W*7
//  commit_P_rd_old out  COMMIT_W*7  freed to free list when commit_wb_en
//  commit_wb_en    out  COMMIT_W
//  ld_commit_cnt   out  $clog2(COMMIT_W+1)  loads retired this cycle
//  st_commit_cnt   out  $clog2(COMMIT_W+1)  stores retired this cycle
//  rb_valid        out  1         rollback of one squashed entry this cycle
//  rb_A_rd/rb_P_rd_old/rb_P_rd_new/rb_wb_en  out 6/7/7/1  restore A_rd->P_rd_old, free P_rd_new
//  recovery        out  1         one-cycle pulse: rollback complete
//  commit_data     out  COMMIT_W*32 retired result (ROB_DATA_EN only)
// BEHAVIOUR
//  Reset: head=tail=0, all valid/done=0, state IDLE; every output 0 except disp_ready=1.
//  Pointers IW+1 bits (wrap bit); empty: head==tail; full: idx equal, wrap differs. age(x)=(x-head) mod DEPTH.
//  Dispatch: on disp_valid&&disp_ready write entry at tail, valid=1 done=0, tail+1 next cycle; idx wraps DEPTH-1->0.
//  WB: each channel sets done[idx] at clk edge; WB to invalid entry ignored; multi-channel same idx legal (last channel wins data).
//  Commit (comb from regs): lane i valid iff lanes 0..i-1 valid && entry head+i valid && done && not beyond tail; head+=count.
//  Done set this cycle retires earliest next cycle. Commit stalls during ROLLBACK.
//  Dispatch into full ROB blocked even if commit frees a slot same cycle (disp_ready uses registered count only).
//  FSM: IDLE --mispredict--> ROLLBACK (stop=mis_rob_idx); ROLLBACK: each cycle, if tail-1!=stop: pop tail-1,
//   drive rb_* from it, clear valid, tail-1; else recovery=1 -> IDLE. Entry at stop never popped.
//  Mispredict same cycle as dispatch: dispatch refused (disp_ready=0 comb on mispredict).
//  Mispredict in ROLLBACK: retarget stop only if age(new)<age(stop); else ignored.
//  Mispredict at tail-1 (youngest): ROLLBACK lasts one cycle, recovery pulses with no rb_valid.
//  Reset mid-ROLLBACK: abandons rollback, returns to reset state, no recovery pulse.
// CONFIGURATION
//  ROB_DATA_EN defined: per-entry 32-bit data array, commit_data driven per lane (0 when lane invalid).
//  Undefined: no data storage, commit_data port absent, wb_data ignored.
// STRUCTURE
//  rob_pkg: rob_entry_t (A_rd, P_rd_new, P_rd_old, wb_en, is_ld, is_st), rob_state_e {IDLE,ROLLBACK}, field-width localparams.
//  Sub-module rob_commit_sel: comb contiguous-ready mask -> commit_valid, count, ld/st counts.
// TESTING
//  Reset, dispatch 8 (DEPTH=8), no WB -> disp_ready=0 after 8th; 9th held; idx 0..7.
//  WB idx 1 then idx 0 next cycle -> nothing retires until idx0 done; next cycle lanes 0,1 commit, head=2.
//  Fill 8, mispredict idx 2 -> rb_valid 5 cycles popping 7..3 with recorded P_rd_old/new, then recovery pulse, tail=3.
//  Head=6 wrap case: dispatch 4 (idx 6,7,0,1), WB all on 2 channels same cycle -> commit 6,7 then 0,1; head=2.
//  ROLLBACK stop=5 then mispredict idx 3 (older) -> retarget, pops continue down to 4; idx 6 mispredict ignored.
//  ROB_DATA_EN: WB 0xDEADBEEF to idx 0 -> commit_data lane0=0xDEADBEEF; ld/st counts match dispatched flags.

Source files
------------

// File: rtl/rob_pkg.sv
// ----------------------------------------------------------------------------
// rob_pkg
// Shared types and field widths for the reorder buffer (reorder_buffer_mw) and
// its commit-select helper (rob_commit_sel).
//   AREG_W / PREG_W / DATA_W : architectural, physical register and data widths
//   rob_entry_t              : per-entry bookkeeping written at dispatch
//   rob_state_e              : IDLE / ROLLBACK control state
// ----------------------------------------------------------------------------
package rob_pkg;

    localparam int AREG_W = 6;
    localparam int PREG_W = 7;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [AREG_W-1:0] A_rd;
        logic [PREG_W-1:0] P_rd_new;
        logic [PREG_W-1:0] P_rd_old;
        logic              wb_en;
        logic              is_ld;
        logic              is_st;
    } rob_entry_t;

    typedef logic [0:0] rob_state_e;
    localparam rob_state_e IDLE     = 1'b0;
    localparam rob_state_e ROLLBACK = 1'b1;

endpackage

// File: rtl/rob_commit_sel.sv
// ----------------------------------------------------------------------------
// rob_commit_sel
// Turns per-lane "entry can retire" flags into a contiguous commit mask:
// lane i retires only if every older lane also retires this cycle.
//   lane_ready   in  COMMIT_W  entry head+i is valid, done and eligible
//   lane_is_ld   in  COMMIT_W  entry head+i is a load
//   lane_is_st   in  COMMIT_W  entry head+i is a store
//   commit_valid out COMMIT_W  contiguous retire mask
//   commit_cnt   out CNT_W     number of lanes retiring
//   ld_cnt       out CNT_W     loads among retiring lanes
//   st_cnt       out CNT_W     stores among retiring lanes
// ----------------------------------------------------------------------------
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] lane_ready,
    input  logic [COMMIT_W-1:0] lane_is_ld,
    input  logic [COMMIT_W-1:0] lane_is_st,
    output logic [COMMIT_W-1:0] commit_valid,
    output logic [CNT_W-1:0]    commit_cnt,
    output logic [CNT_W-1:0]    ld_cnt,
    output logic [CNT_W-1:0]    st_cnt
);

    logic run;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned (no latch); blocking '=' is used because later
    // iterations must see the values produced by earlier ones.
    always_comb begin
        commit_valid = '0;
        commit_cnt   = '0;
        ld_cnt       = '0;
        st_cnt       = '0;
        run          = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            commit_valid[i] = run && lane_ready[i];
            run             = commit_valid[i];
            if (commit_valid[i]) begin
                commit_cnt = commit_cnt + CNT_W'(1);
                if (lane_is_ld[i]) ld_cnt = ld_cnt + CNT_W'(1);
                if (lane_is_st[i]) st_cnt = st_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mw.sv
// ----------------------------------------------------------------------------
// reorder_buffer_mw
// In-order-retire reorder buffer: one dispatch per cycle, WB_CH writeback
// channels, up to COMMIT_W retires per cycle, and a walk-back recovery that
// pops squashed entries youngest-first (one per cycle) after a mispredict.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   disp_*                        dispatch handshake and entry payload
//   disp_rob_idx                  index allocated on handshake (tail)
//   wb_valid/wb_rob_idx/wb_data   per-channel completion
//   mispredict/mis_rob_idx        branch resolved wrong; younger squashed
//   commit_*                      per-lane retire information
//   ld_commit_cnt/st_commit_cnt   loads/stores retired this cycle
//   rb_*                          one squashed entry rolled back this cycle
//   recovery                      one-cycle pulse: rollback finished
//   commit_data                   retired results (ROB_DATA_EN only)
//
// Configuration macro: ROB_DATA_EN -- when defined, a per-entry 32-bit result
// array is kept and commit_data is present; otherwise wb_data is ignored.
// ----------------------------------------------------------------------------
module reorder_buffer_mw
    import rob_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_CH    = 2,
    parameter int COMMIT_W = 2,
    parameter int IW       = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [AREG_W-1:0]          disp_A_rd,
    input  logic [PREG_W-1:0]          disp_P_rd_new,
    input  logic [PREG_W-1:0]          disp_P_rd_old,
    input  logic                       disp_wb_en,
    input  logic                       disp_is_ld,
    input  logic                       disp_is_st,
    output logic [IW-1:0]              disp_rob_idx,
    input  logic [WB_CH-1:0]           wb_valid,
    input  logic [WB_CH*IW-1:0]        wb_rob_idx,
    input  logic [WB_CH*DATA_W-1:0]    wb_data,
    input  logic                       mispredict,
    input  logic [IW-1:0]              mis_rob_idx,
    output logic [COMMIT_W-1:0]        commit_valid,
    output logic [COMMIT_W*AREG_W-1:0] commit_A_rd,
    output logic [COMMIT_W*PREG_W-1:0] commit_P_rd_new,
    output logic [COMMIT_W*PREG_W-1:0] commit_P_rd_old,
    output logic [COMMIT_W-1:0]        commit_wb_en,
`ifdef ROB_DATA_EN
    output logic [COMMIT_W*DATA_W-1:0] commit_data,
`endif
    output logic [CNT_W-1:0]           ld_commit_cnt,
    output logic [CNT_W-1:0]           st_commit_cnt,
    output logic                       rb_valid,
    output logic [AREG_W-1:0]          rb_A_rd,
    output logic [PREG_W-1:0]          rb_P_rd_old,
    output logic [PREG_W-1:0]          rb_P_rd_new,
    output logic                       rb_wb_en,
    output logic                       recovery
);

    localparam int PTR_W = IW + 1;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] head, tail, tail_m1, count;
    logic [IW-1:0]    head_idx, tail_idx, last_idx, stop, mis_age, stop_age;
    logic [DEPTH-1:0] valid, done;
    rob_entry_t       entries [DEPTH];
    rob_state_e       state;

    logic full, disp_fire, at_stop, retarget;
    logic [COMMIT_W-1:0] lane_ready, lane_is_ld, lane_is_st;
    logic [IW-1:0]       lane_idx [COMMIT_W];
    logic [CNT_W-1:0]    commit_cnt;

    assign count     = tail - head;
    assign tail_m1   = tail - PTR_W'(1);
    assign head_idx  = head[IW-1:0];
    assign tail_idx  = tail[IW-1:0];
    assign last_idx  = tail_m1[IW-1:0];
    assign full      = (count == PTR_W'(DEPTH));

    // Ages are measured from head so older/younger compares survive wrap.
    assign mis_age   = mis_rob_idx - head_idx;
    assign stop_age  = stop - head_idx;

    assign disp_ready   = !full && (state == IDLE) && !mispredict;
    assign disp_fire    = disp_valid && disp_ready;
    assign disp_rob_idx = tail_idx;

    // Rollback: pop tail-1 until it reaches the kept (mispredicting) entry.
    // A retarget arriving on the would-be final cycle keeps the walk going.
    assign at_stop  = (last_idx == stop);
    assign retarget = (state == ROLLBACK) && mispredict && (mis_age < stop_age);
    assign rb_valid = (state == ROLLBACK) && !at_stop;
    assign recovery = (state == ROLLBACK) && at_stop && !retarget;

    assign rb_A_rd     = rb_valid ? entries[last_idx].A_rd     : '0;
    assign rb_P_rd_old = rb_valid ? entries[last_idx].P_rd_old : '0;
    assign rb_P_rd_new = rb_valid ? entries[last_idx].P_rd_new : '0;
    assign rb_wb_en    = rb_valid ? entries[last_idx].wb_en    : 1'b0;

    // Per-lane eligibility. On a mispredict cycle, entries younger than the
    // branch must not slip out before the squash takes effect.
    always_comb begin
        lane_ready = '0;
        lane_is_ld = '0;
        lane_is_st = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_idx[i]   = head_idx + IW'(i);
            lane_ready[i] = (state == IDLE) && (PTR_W'(i) < count) &&
                            valid[lane_idx[i]] && done[lane_idx[i]] &&
                            !(mispredict && (IW'(i) > mis_age));
            lane_is_ld[i] = entries[lane_idx[i]].is_ld;
            lane_is_st[i] = entries[lane_idx[i]].is_st;
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (CNT_W)
    ) u_commit_sel (
        .lane_ready   (lane_ready),
        .lane_is_ld   (lane_is_ld),
        .lane_is_st   (lane_is_st),
        .commit_valid (commit_valid),
        .commit_cnt   (commit_cnt),
        .ld_cnt       (ld_commit_cnt),
        .st_cnt       (st_commit_cnt)
    );

    always_comb begin
        commit_A_rd     = '0;
        commit_P_rd_new = '0;
        commit_P_rd_old = '0;
        commit_wb_en    = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (commit_valid[i]) begin
                commit_A_rd[i*AREG_W +: AREG_W]     = entries[lane_idx[i]].A_rd;
                commit_P_rd_new[i*PREG_W +: PREG_W] = entries[lane_idx[i]].P_rd_new;
                commit_P_rd_old[i*PREG_W +: PREG_W] = entries[lane_idx[i]].P_rd_old;
                commit_wb_en[i]                     = entries[lane_idx[i]].wb_en;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            state <= IDLE;
            stop  <= '0;
        end else begin
            head <= head + PTR_W'(commit_cnt);
            if (rb_valid)       tail <= tail_m1;
            else if (disp_fire) tail <= tail + PTR_W'(1);

            for (int c = 0; c < WB_CH; c++) begin
                if (wb_valid[c] && valid[wb_rob_idx[c*IW +: IW]])
                    done[wb_rob_idx[c*IW +: IW]] <= 1'b1;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (commit_valid[i]) valid[lane_idx[i]] <= 1'b0;
            end
            if (disp_fire) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= 1'b0;
            end
            if (rb_valid) valid[last_idx] <= 1'b0;

            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state <= ROLLBACK;
                        stop  <= mis_rob_idx;
                    end
                end
                default: begin
                    if (retarget)     stop  <= mis_rob_idx;
                    else if (at_stop) state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROB_DATA_EN
    logic [DATA_W-1:0] data_q [DEPTH];

    always_comb begin
        commit_data = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (commit_valid[i]) commit_data[i*DATA_W +: DATA_W] = data_q[lane_idx[i]];
        end
    end
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
`endif

    // NOTE: payload storage has no reset; it is only ever read through a
    // set valid bit, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            entries[tail_idx] <= '{A_rd: disp_A_rd, P_rd_new: disp_P_rd_new,
                                   P_rd_old: disp_P_rd_old, wb_en: disp_wb_en,
                                   is_ld: disp_is_ld, is_st: disp_is_st};
        end
`ifdef ROB_DATA_EN
        // Higher-numbered channel wins when two write the same entry.
        for (int c = 0; c < WB_CH; c++) begin
            if (wb_valid[c] && valid[wb_rob_idx[c*IW +: IW]])
                data_q[wb_rob_idx[c*IW +: IW]] <= wb_data[c*DATA_W +: DATA_W];
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer_mw
// Directed bench for reorder_buffer_mw (DEPTH=8, WB_CH=2, COMMIT_W=2).
// Covers reset, fill/full, out-of-order writeback, multi-commit across wrap,
// rollback walk, retarget, youngest-entry mispredict, reset mid-rollback and,
// with ROB_DATA_EN defined, commit_data.
// ----------------------------------------------------------------------------
module tb_reorder_buffer_mw;

    localparam int DEPTH    = 8;
    localparam int WB_CH    = 2;
    localparam int COMMIT_W = 2;
    localparam int IW       = 3;
    localparam int CNT_W    = 2;

    logic                 clk, rst;
    logic                 disp_valid, disp_ready;
    logic [5:0]           disp_A_rd;
    logic [6:0]           disp_P_rd_new, disp_P_rd_old;
    logic                 disp_wb_en, disp_is_ld, disp_is_st;
    logic [IW-1:0]        disp_rob_idx;
    logic [WB_CH-1:0]     wb_valid;
    logic [WB_CH*IW-1:0]  wb_rob_idx;
    logic [WB_CH*32-1:0]  wb_data;
    logic                 mispredict;
    logic [IW-1:0]        mis_rob_idx;
    logic [COMMIT_W-1:0]  commit_valid, commit_wb_en;
    logic [COMMIT_W*6-1:0] commit_A_rd;
    logic [COMMIT_W*7-1:0] commit_P_rd_new, commit_P_rd_old;
`ifdef ROB_DATA_EN
    logic [COMMIT_W*32-1:0] commit_data;
`endif
    logic [CNT_W-1:0]     ld_commit_cnt, st_commit_cnt;
    logic                 rb_valid, rb_wb_en, recovery;
    logic [5:0]           rb_A_rd;
    logic [6:0]           rb_P_rd_old, rb_P_rd_new;

    int checks = 0;
    int errors = 0;

    reorder_buffer_mw #(.DEPTH(DEPTH), .WB_CH(WB_CH), .COMMIT_W(COMMIT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_A_rd       (disp_A_rd),
        .disp_P_rd_new   (disp_P_rd_new),
        .disp_P_rd_old   (disp_P_rd_old),
        .disp_wb_en      (disp_wb_en),
        .disp_is_ld      (disp_is_ld),
        .disp_is_st      (disp_is_st),
        .disp_rob_idx    (disp_rob_idx),
        .wb_valid        (wb_valid),
        .wb_rob_idx      (wb_rob_idx),
        .wb_data         (wb_data),
        .mispredict      (mispredict),
        .mis_rob_idx     (mis_rob_idx),
        .commit_valid    (commit_valid),
        .commit_A_rd     (commit_A_rd),
        .commit_P_rd_new (commit_P_rd_new),
        .commit_P_rd_old (commit_P_rd_old),
        .commit_wb_en    (commit_wb_en),
`ifdef ROB_DATA_EN
        .commit_data     (commit_data),
`endif
        .ld_commit_cnt   (ld_commit_cnt),
        .st_commit_cnt   (st_commit_cnt),
        .rb_valid        (rb_valid),
        .rb_A_rd         (rb_A_rd),
        .rb_P_rd_old     (rb_P_rd_old),
        .rb_P_rd_new     (rb_P_rd_new),
        .rb_wb_en        (rb_wb_en),
        .recovery        (recovery)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int a, input int pn, input int po,
                            input logic we, input logic ld, input logic st);
        disp_valid    = 1'b1;
        disp_A_rd     = 6'(a);
        disp_P_rd_new = 7'(pn);
        disp_P_rd_old = 7'(po);
        disp_wb_en    = we;
        disp_is_ld    = ld;
        disp_is_st    = st;
    endtask

    task automatic set_wb(input logic [1:0] v, input int i0, input int i1,
                          input logic [31:0] d0, input logic [31:0] d1);
        wb_valid   = v;
        wb_rob_idx = {IW'(i1), IW'(i0)};
        wb_data    = {d1, d0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; disp_valid = 0; disp_A_rd = 0; disp_P_rd_new = 0; disp_P_rd_old = 0;
        disp_wb_en = 0; disp_is_ld = 0; disp_is_st = 0; mispredict = 0; mis_rob_idx = 0;
        set_wb(2'b00, 0, 0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_ready", disp_ready, 1);
        check("rst_idx", disp_rob_idx, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_rb", {rb_valid, recovery}, 0);
        check("rst_cnts", {ld_commit_cnt, st_commit_cnt}, 0);

        // Fill all 8 entries without writeback; the 9th offer is held off
        for (int i = 0; i < 8; i++) begin
            dispatch(i + 1, 16 + i, 32 + i, 1'b1, i == 0, i == 1);
            #1;
            check("fill_ready", disp_ready, 1);
            check("fill_idx", disp_rob_idx, i);
            tick();
        end
        #1;
        check("full_ready", disp_ready, 0);
        tick();
        check("full_hold_idx", disp_rob_idx, 0);
        check("full_no_commit", commit_valid, 0);
        disp_valid = 0;

        // Writeback idx1 first, then idx0: nothing retires until idx0 is done
        set_wb(2'b01, 1, 0, 0, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0);
        #1;
        check("ooo_wait", commit_valid, 0);
        set_wb(2'b01, 0, 0, 0, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0);
        #1;
        check("ooo_commit", commit_valid, 2'b11);
        check("ooo_A_rd", commit_A_rd, {6'd2, 6'd1});
        check("ooo_P_old", commit_P_rd_old, {7'd33, 7'd32});
        check("ooo_P_new", commit_P_rd_new, {7'd17, 7'd16});
        check("ooo_wb_en", commit_wb_en, 2'b11);
        check("ooo_ld_st", {ld_commit_cnt, st_commit_cnt}, {2'd1, 2'd1});
        check("ooo_ready_registered", disp_ready, 0);
        tick();
        #1;
        check("ooo_after", commit_valid, 0);
        check("ooo_ready_after", disp_ready, 1);

        // Fill 8 and mispredict idx 2: walk back 7..3 then recovery
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatch(10 + i, 40 + i, 80 + i, i[0], 0, 0);
            tick();
        end
        disp_valid = 0;
        mispredict = 1; mis_rob_idx = 3'd2;
        #1;
        check("mis_blocks_disp", disp_ready, 0);
        tick();
        mispredict = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rb_valid", rb_valid, 1);
            check("rb_fields", {rb_A_rd, rb_P_rd_old, rb_P_rd_new, rb_wb_en},
                  {6'(17 - k), 7'(87 - k), 7'(47 - k), 1'((7 - k) % 2)});
            check("rb_no_recovery", recovery, 0);
            tick();
        end
        #1;
        check("rb_done", {rb_valid, recovery}, 2'b01);
        tick();
        check("rb_after", {recovery, disp_ready}, 2'b01);
        check("rb_tail", disp_rob_idx, 3);

        // Head wraps: retire 0..5 in pairs, then dispatch 6,7,0,1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dispatch(20 + i, 50 + i, 90 + i, 1'b1, (i % 3) == 0, (i % 3) == 1);
            tick();
        end
        disp_valid = 0;
        for (int p = 0; p < 3; p++) begin
            set_wb(2'b11, 2 * p, 2 * p + 1, 0, 0);
            tick();
            set_wb(2'b00, 0, 0, 0, 0);
            #1;
            check("pair_commit", commit_valid, 2'b11);
            check("pair_A_rd", commit_A_rd, {6'(21 + 2 * p), 6'(20 + 2 * p)});
            check("pair_ld", ld_commit_cnt, (p == 2) ? 0 : 1);
            check("pair_st", st_commit_cnt, (p == 1) ? 0 : 1);
        end
        tick();
        check("pair_drained", commit_valid, 0);
        check("wrap_tail", disp_rob_idx, 6);
        for (int j = 0; j < 4; j++) begin
            dispatch(30 + j, 60 + j, 100 + j, 1'b0, 1'b1, 1'b0);
            #1;
            check("wrap_idx", disp_rob_idx, (6 + j) % 8);
            tick();
        end
        disp_valid = 0;
        set_wb(2'b11, 0, 1, 0, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0);
        #1;
        check("wrap_head_wait", commit_valid, 0);
        set_wb(2'b11, 6, 7, 0, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0);
        #1;
        check("wrap_c67", commit_valid, 2'b11);
        check("wrap_c67_A", commit_A_rd, {6'd31, 6'd30});
        check("wrap_c67_wb_en", commit_wb_en, 2'b00);
        check("wrap_c67_ld", ld_commit_cnt, 2);
        tick();
        check("wrap_c01", commit_valid, 2'b11);
        check("wrap_c01_A", commit_A_rd, {6'd33, 6'd32});
        tick();
        check("wrap_empty", commit_valid, 0);
        check("wrap_tail_end", disp_rob_idx, 2);

        // Retarget: stop=5, then older idx 3 retargets, younger idx 6 ignored
        do_reset();
        for (int i = 0; i < 7; i++) begin
            dispatch(40 + i, 60 + i, 100 + i, 1'b1, 0, 0);
            tick();
        end
        dispatch(47, 67, 107, 1'b1, 0, 0);
        mispredict = 1; mis_rob_idx = 3'd5;
        #1;
        check("mis_disp_refused", disp_ready, 0);
        tick();
        disp_valid = 0;
        mis_rob_idx = 3'd3;
        #1;
        check("rt_pop6", {rb_valid, rb_A_rd, recovery}, {1'b1, 6'd46, 1'b0});
        tick();
        mis_rob_idx = 3'd6;
        #1;
        check("rt_pop5", {rb_valid, rb_A_rd}, {1'b1, 6'd45});
        tick();
        mispredict = 0;
        #1;
        check("rt_pop4", {rb_valid, rb_A_rd, recovery}, {1'b1, 6'd44, 1'b0});
        tick();
        check("rt_recovery", {rb_valid, recovery}, 2'b01);
        tick();
        check("rt_tail", disp_rob_idx, 4);
        check("rt_idle", {recovery, disp_ready}, 2'b01);

        // Mispredict on youngest entry: recovery with no pops
        mispredict = 1; mis_rob_idx = 3'd3;
        tick();
        mispredict = 0;
        #1;
        check("young_recovery", {rb_valid, recovery}, 2'b01);
        tick();
        check("young_after", {recovery, disp_rob_idx}, {1'b0, 3'd4});

        // Reset in the middle of a rollback
        mispredict = 1; mis_rob_idx = 3'd0;
        tick();
        mispredict = 0;
        #1;
        check("mid_rb_pop", {rb_valid, rb_A_rd}, {1'b1, 6'd43});
        rst = 1;
        tick();
        check("mid_rst", {rb_valid, recovery, disp_ready, disp_rob_idx}, {3'b001, 3'd0});
        rst = 0;
        tick();
        check("mid_rst_after", {rb_valid, recovery}, 2'b00);

`ifdef ROB_DATA_EN
        // Result data: two channels hit idx 0, channel 1 wins
        dispatch(1, 2, 3, 1'b1, 1'b1, 1'b0);
        tick();
        dispatch(4, 5, 6, 1'b1, 1'b0, 1'b1);
        tick();
        disp_valid = 0;
        set_wb(2'b11, 0, 0, 32'h0000_0111, 32'hDEAD_BEEF);
        tick();
        set_wb(2'b00, 0, 0, 0, 0);
        #1;
        check("data_commit", commit_valid, 2'b01);
        check("data_value", commit_data, 64'h0000_0000_DEAD_BEEF);
        check("data_ld_st", {ld_commit_cnt, st_commit_cnt}, {2'd1, 2'd0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
